// File: rtl/cmp_arbiter.sv
// Round-robin arbiter that time-shares one unsigned comparator among NREQ
// requesters and returns registered flags tagged with the requester index.

module comparator #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             equal,
    output logic             lower,
    output logic             greater
);
    assign equal   = (a == b);
    assign lower   = (a < b);
    assign greater = (a > b);
endmodule

module cmp_arbiter #(
    parameter  int WIDTH = 4,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_equal,
    output logic                  rsp_lower,
    output logic                  rsp_greater,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IDW-1:0]   ptr_r;
    logic [IDW-1:0]   id_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IDW-1:0]   rsp_id_r;
    logic             rsp_valid_r;
    logic             rsp_equal_r;
    logic             rsp_lower_r;
    logic             rsp_greater_r;

    logic             grant_found_s;
    logic [IDW-1:0]   grant_id_s;
    logic [IDW-1:0]   cand_s;
    logic [NREQ-1:0]  req_ready_s;
    logic             cmp_equal_s;
    logic             cmp_lower_s;
    logic             cmp_greater_s;

    comparator #(.WIDTH(WIDTH)) u_comparator (
        .a       (a_r),
        .b       (b_r),
        .equal   (cmp_equal_s),
        .lower   (cmp_lower_s),
        .greater (cmp_greater_s)
    );

    // Round-robin search starting just after the last served requester.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        cand_s        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IDW'((int'(ptr_r) + k) % NREQ);
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Grant is only offered in IDLE; held at zero while reset is asserted.
    always_comb begin
        req_ready_s = '0;
        if (rst_n && (state_r == IDLE) && grant_found_s) begin
            req_ready_s[grant_id_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Next-state logic for the accept / compare / respond sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_found_s) begin
                    state_s = CMP;
                end else begin
                    state_s = IDLE;
                end
            end
            CMP:  state_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, operand latch, result registers and priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            ptr_r         <= IDW'(NREQ - 1);
            id_r          <= '0;
            a_r           <= '0;
            b_r           <= '0;
            rsp_id_r      <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_equal_r   <= 1'b0;
            rsp_lower_r   <= 1'b0;
            rsp_greater_r <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        a_r  <= req_a[grant_id_s*WIDTH +: WIDTH];
                        b_r  <= req_b[grant_id_s*WIDTH +: WIDTH];
                        id_r <= grant_id_s;
                    end
                end
                CMP: begin
                    rsp_id_r      <= id_r;
                    rsp_equal_r   <= cmp_equal_s;
                    rsp_lower_r   <= cmp_lower_s;
                    rsp_greater_r <= cmp_greater_s;
                    rsp_valid_r   <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        ptr_r       <= id_r;
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end

    assign req_ready   = req_ready_s;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_id      = rsp_id_r;
    assign rsp_equal   = rsp_equal_r;
    assign rsp_lower   = rsp_lower_r;
    assign rsp_greater = rsp_greater_r;
    assign busy        = (state_r != IDLE);
endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed scenarios plus randomized
// traffic compared against a round-robin reference model.

module tb_cmp_arbiter;
    localparam int W = 4;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic          rsp_equal;
    logic          rsp_lower;
    logic          rsp_greater;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int ptr_m    = N - 1;

    cmp_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_equal   (rsp_equal),
        .rsp_lower   (rsp_lower),
        .rsp_greater (rsp_greater),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // First valid requester scanning upward from ptr+1, wrapping.
    function automatic int exp_winner(input logic [N-1:0] m, input int p);
        for (int k = 1; k <= N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // {equal, lower, greater} for an unsigned pair.
    function automatic logic [2:0] exp_flags(input int a, input int b);
        return {a == b, a < b, a > b};
    endfunction

    task automatic apply_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        ptr_m = N - 1;
    endtask

    // Runs one request to completion and reports what the DUT did.
    task automatic run_one(input logic [N-1:0] vmask, input logic [N*W-1:0] av,
                           input logic [N*W-1:0] bv, input int hold,
                           output logic [N-1:0] gnt, output logic [1:0] id,
                           output logic [2:0] flags, output int gwait, output int lat,
                           output bit tmo, output bit stable);
        req_a     = av;
        req_b     = bv;
        req_valid = vmask;
        rsp_ready = 1'b0;
        tmo       = 1'b0;
        stable    = 1'b1;
        gwait     = 0;
        #1;
        while (req_ready == '0 && gwait < 20) begin
            tick();
            gwait++;
        end
        if (req_ready == '0) tmo = 1'b1;
        gnt = req_ready;
        tick();
        req_valid = req_valid & ~gnt;
        rsp_ready = 1'($urandom_range(0, 1));
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            rsp_ready = 1'b0;
            lat++;
        end
        rsp_ready = 1'b0;
        if (!rsp_valid) tmo = 1'b1;
        id    = rsp_id;
        flags = {rsp_equal, rsp_lower, rsp_greater};
        for (int h = 0; h < hold; h++) begin
            tick();
            if (!rsp_valid || rsp_id !== id || {rsp_equal, rsp_lower, rsp_greater} !== flags)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        tick();
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_equal, rsp_lower, rsp_greater, busy} !== 11'd0) begin
            failures++;
            $display("FAIL reset_values: got ready=%b v=%b id=%0d flags=%b%b%b busy=%b, want all zero",
                     req_ready, rsp_valid, rsp_id, rsp_equal, rsp_lower, rsp_greater, busy);
        end
        rst_n     = 1'b1;
        req_valid = '0;
        ptr_m     = N - 1;
    endtask

    task automatic test_single;
        logic [N-1:0] g; logic [1:0] id; logic [2:0] f; int gw, lat; bit tmo, st;
        apply_reset();
        run_one(4'b0100, 16'h0500, 16'h0900, 0, g, id, f, gw, lat, tmo, st);
        checks++;
        if (tmo || g !== 4'b0100 || gw != 0) begin
            failures++;
            $display("FAIL single_grant: got gnt=%b wait=%0d tmo=%0d, want 0100 wait=0", g, gw, tmo);
        end
        checks++;
        if (lat != 2 || id !== 2'd2 || f !== 3'b010) begin
            failures++;
            $display("FAIL single_rsp: got lat=%0d id=%0d eq/lo/gr=%b, want lat=2 id=2 010", lat, id, f);
        end
        ptr_m = 2;
    endtask

    task automatic test_extremes;
        logic [N-1:0] g; logic [1:0] id; logic [2:0] f; int gw, lat; bit tmo, st;
        logic [3:0] ta[3] = '{4'd15, 4'd0, 4'd15};
        logic [3:0] tb[3] = '{4'd15, 4'd15, 4'd0};
        logic [2:0] te[3] = '{3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 3; i++) begin
            run_one(4'b0010, {8'h00, ta[i], 4'h0}, {8'h00, tb[i], 4'h0}, 0, g, id, f, gw, lat, tmo, st);
            checks++;
            if (tmo || id !== 2'd1 || f !== te[i]) begin
                failures++;
                $display("FAIL extreme_%0d: got id=%0d flags=%b tmo=%0d, want id=1 flags=%b", i, id, f, tmo, te[i]);
            end
        end
        ptr_m = 1;
    endtask

    task automatic test_contention;
        int gid[$]; int gcyc[$]; int rid[$]; int rcyc[$]; logic [2:0] rfl[$];
        int exp_rsp_cyc;
        logic [N*W-1:0] av, bv;
        apply_reset();
        av = N*W'($urandom);
        bv = N*W'($urandom);
        req_a = av; req_b = bv;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i]) begin gid.push_back(i); gcyc.push_back(c); end
            if (rsp_valid) begin
                rid.push_back(rsp_id); rcyc.push_back(c);
                rfl.push_back({rsp_equal, rsp_lower, rsp_greater});
            end
            @(posedge clk);
        end
        #1;
        rsp_ready = 1'b0;
        req_valid = '0;
        checks++;
        if (gid.size() != 5 || rid.size() != 5) begin
            failures++;
            $display("FAIL contention_count: got grants=%0d rsps=%0d, want 5 and 5", gid.size(), rid.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                exp_rsp_cyc = 3 * k + 2;
                checks++;
                if (gid[k] != k % N || gcyc[k] != 3 * k || rid[k] != k % N || rcyc[k] != exp_rsp_cyc ||
                    rfl[k] !== exp_flags(av[(k%N)*W +: W], bv[(k%N)*W +: W])) begin
                    failures++;
                    $display("FAIL contention_%0d: got gnt=%0d@%0d rsp=%0d@%0d fl=%b, want %0d@%0d %0d@%0d fl=%b",
                             k, gid[k], gcyc[k], rid[k], rcyc[k], rfl[k], k % N, 3 * k, k % N, exp_rsp_cyc,
                             exp_flags(av[(k%N)*W +: W], bv[(k%N)*W +: W]));
                end
            end
        end
    endtask

    task automatic test_fairness;
        logic [N-1:0] g; logic [1:0] id; logic [2:0] f; int gw, lat; bit tmo, st;
        apply_reset();
        run_one(4'b0100, '0, '0, 0, g, id, f, gw, lat, tmo, st);
        run_one(4'b1001, '0, '0, 0, g, id, f, gw, lat, tmo, st);
        checks++;
        if (tmo || g !== 4'b1000) begin
            failures++;
            $display("FAIL fair_first: got gnt=%b, want 1000", g);
        end
        run_one(4'b0001, '0, '0, 0, g, id, f, gw, lat, tmo, st);
        checks++;
        if (tmo || g !== 4'b0001 || id !== 2'd0) begin
            failures++;
            $display("FAIL fair_second: got gnt=%b id=%0d, want 0001 id=0", g, id);
        end
    endtask

    task automatic test_backpressure;
        logic [N*W-1:0] av, bv;
        logic [2:0] ef;
        bit bad;
        apply_reset();
        av = N*W'($urandom); bv = N*W'($urandom);
        req_a = av; req_b = bv;
        ef = exp_flags(av[3:0], bv[3:0]);
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = 4'b0010;
        tick();
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!rsp_valid || req_ready !== '0 || rsp_id !== 2'd0 ||
                {rsp_equal, rsp_lower, rsp_greater} !== ef || !busy) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad || !rsp_valid) begin
            failures++;
            $display("FAIL backpressure_hold: got v=%b ready=%b id=%0d fl=%b%b%b, want v=1 ready=0 id=0 fl=%b",
                     rsp_valid, req_ready, rsp_id, rsp_equal, rsp_lower, rsp_greater, ef);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid || req_ready !== 4'b0010 || busy) begin
            failures++;
            $display("FAIL backpressure_release: got v=%b ready=%b busy=%b, want v=0 ready=0010 busy=0",
                     rsp_valid, req_ready, busy);
        end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (!rsp_valid || rsp_id !== 2'd1) begin
            failures++;
            $display("FAIL backpressure_next: got v=%b id=%0d, want v=1 id=1", rsp_valid, rsp_id);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit seen;
        apply_reset();
        req_a = 16'hFFFF; req_b = 16'h0000;
        req_valid = 4'b1001;
        tick();
        req_valid = 4'b1001;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_equal, rsp_lower, rsp_greater, busy} !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid_values: got ready=%b v=%b id=%0d flags=%b%b%b busy=%b, want all zero",
                     req_ready, rsp_valid, rsp_id, rsp_equal, rsp_lower, rsp_greater, busy);
        end
        tick();
        rst_n = 1'b1;
        req_valid = '0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_mid_no_rsp: got stray rsp_valid=1, want 0");
        end
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset_mid_grant0: got ready=%b, want 0001", req_ready);
        end
        apply_reset();
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL reset_mid_grant3: got ready=%b, want 1000", req_ready);
        end
        apply_reset();
    endtask

    task automatic test_random;
        logic [N-1:0] g; logic [1:0] id; logic [2:0] f; int gw, lat; bit tmo, st;
        logic [N-1:0] m; logic [N*W-1:0] av, bv; int w;
        for (int t = 0; t < 40; t++) begin
            m  = N'($urandom_range(1, 15));
            av = N*W'($urandom);
            bv = N*W'($urandom);
            if ($urandom_range(0, 3) == 0) bv = av;
            w = exp_winner(m, ptr_m);
            run_one(m, av, bv, $urandom_range(0, 3), g, id, f, gw, lat, tmo, st);
            checks++;
            if (tmo || !st || lat != 2 || gw != 0 || g !== N'(1 << w) || id !== 2'(w) ||
                f !== exp_flags(av[w*W +: W], bv[w*W +: W])) begin
                failures++;
                $display("FAIL random_%0d: got gnt=%b id=%0d fl=%b lat=%0d st=%0d, want gnt=%b id=%0d fl=%b lat=2",
                         t, g, id, f, lat, st, N'(1 << w), w, exp_flags(av[w*W +: W], bv[w*W +: W]));
            end
            ptr_m = w;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin arbiter and sequencer that shares one `comparator` instance (equal/lower/greater over WIDTH-bit unsigned operands) among NREQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester at a time, latches its operands, registers the comparator flags, and returns them tagged with the requester index over a second valid/ready handshake. It sits between the requesting datapath blocks and the shared compare resource.

## Interface
- `WIDTH`, default 4: operand width in bits; passed to the `comparator` instance.
- `NREQ`, default 4: number of requesters, ≥2. `IDW = $clog2(NREQ)`.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `req_valid` input, NREQ bits: bit i set means requester i offers an operand pair.
- `req_a` input, NREQ*WIDTH bits: operand a of requester i at `[i*WIDTH +: WIDTH]`.
- `req_b` input, NREQ*WIDTH bits: operand b of requester i, same packing as `req_a`.
- `req_ready` output, NREQ bits: one-hot or zero; bit i means requester i's pair is accepted this cycle.
- `rsp_valid` output, 1 bit: result available.
- `rsp_ready` input, 1 bit: consumer accepts the result.
- `rsp_id` output, IDW bits: index of the requester that produced the result.
- `rsp_equal`, `rsp_lower`, `rsp_greater` outputs, 1 bit each: registered comparator flags for the latched a versus b.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, CMP, RESP.
- **IDLE**
  - The grant is combinational.
  - The search starts at requester `(ptr+1) mod NREQ` and wraps. The first i with `req_valid[i]` wins.
  - `req_ready[i]` is driven to 1 for the winner only. All other bits are 0.
  - On that edge the block latches `a_q`, `b_q` and `id_q = i`, then moves to CMP.
  - If no bit of `req_valid` is set, the block stays in IDLE and `req_ready = 0`.
- **CMP**
  - `comparator` is driven from `a_q`/`b_q`.
  - On the edge its outputs load into `rsp_equal`/`rsp_lower`/`rsp_greater`, and `rsp_id` loads `id_q`.
  - The state moves to RESP.
  - `req_ready = 0`.
- **RESP**
  - `rsp_valid = 1`.
  - The block holds all rsp outputs stable until `rsp_valid && rsp_ready`.
  - On that edge: `ptr <= id_q`, the state moves to IDLE, and `rsp_valid` drops.
  - `req_ready = 0`.
- Exactly one of the three flags is 1 whenever `rsp_valid = 1`. Comparison is unsigned.
- Requester rule: a requester holds `req_valid` and its operands stable until it sees `req_ready`. The arbiter does not check this rule.
- Fairness: the requester just served becomes the lowest priority. With all NREQ requesters continuously valid, grants rotate 0, 1, …, NREQ-1, 0, …
- Simultaneous events: a new request arriving in CMP or RESP waits. It is arbitrated in the next IDLE cycle against the pointer as updated by the completed response.

## Timing
- Reset values, applied asynchronously on `rst_n = 0`:
  - state IDLE
  - `ptr = NREQ-1`, so requester 0 has top priority after reset
  - `rsp_valid = 0`, `rsp_id = 0`, all flags 0
  - `req_ready = 0`, `busy = 0`
- Reset mid-operation discards the latched pair and any pending result. No response is emitted for it.
- Latency: acceptance edge T (IDLE, `req_ready` high), CMP during T+1, `rsp_valid` high from cycle T+2.
- Throughput: with `rsp_ready` tied high, one result every 3 cycles.
- `req_ready` is combinational from `req_valid`, `ptr` and state. It has no dependence on `rsp_ready`.
- A `rsp_ready` pulse while `rsp_valid = 0` has no effect.

## Test plan
- **Single request:** WIDTH=4; requester 2 presents a=5, b=9 at cycle 0 → `req_ready = 4'b0100` in cycle 0; `rsp_valid` in cycle 2 with id=2, lower=1, equal=0, greater=0.
- **Equal and extreme operands:** a=15, b=15 → equal=1. Then a=0, b=15 → lower=1. Then a=15, b=0 → greater=1. Only one flag is high each time.
- **Full contention after reset:** all four requesters valid continuously → grant order 0, 1, 2, 3, 0; a new `rsp_valid` every 3 cycles; `rsp_id` matches the grant order.
- **Pointer fairness:** serve requester 2, then assert requesters 0 and 3 together → 3 is granted first, then 0.
- **Backpressure:** hold `rsp_ready = 0` for 5 cycles in RESP while requester 1 is valid → `rsp_valid` and the flags stay stable; `req_ready` stays 0; requester 1 is accepted in the IDLE cycle after the handshake.
- **Reset mid-operation:** drop `rst_n` in CMP → all outputs read their reset values immediately. After release, a pending requester 3 is granted before 0 only if requester 0 is not valid.
